// File: rtl/vga_fb_display.sv
// VGA timing generator with an RGB332 texel framebuffer, each texel scaled by SCALE in both axes.
// Optional macro VGA_DOUBLE_BUF_EN: two banks with a front/back swap taken at the start of vblank.
module vga_fb_display #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SCALE    = 8,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned ADDR_W   = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fb_we,
    input  logic [ADDR_W-1:0] fb_waddr,
    input  logic [7:0]        fb_wdata,
    input  logic              swap_req,
    output logic              swap_busy,
    output logic              front_sel,
    output logic              clk_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out,
    output logic [7:0]        o_red,
    output logic [7:0]        o_green,
    output logic [7:0]        o_blue
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FB_W    = H_ACTIVE / SCALE;
    localparam int unsigned FB_H    = V_ACTIVE / SCALE;
    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef VGA_DOUBLE_BUF_EN
    localparam int unsigned NBANK   = 2;
`else
    localparam int unsigned NBANK   = 1;
`endif
    localparam int unsigned MEM_DEPTH = NBANK * FB_SIZE;
    localparam int unsigned MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W + 1)'(FB_SIZE);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              clk_out_q, clk_out_d;
    logic [H_W-1:0]    h_cnt_q, h_cnt_d;
    logic [V_W-1:0]    v_cnt_q, v_cnt_d;
    logic              hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [7:0]        rd_data_q;
    logic              pix_en_c, active_c, hs_act_c, vs_act_c, wr_en_c;
    logic [31:0]       h_ext, v_ext, texel_c;
    logic [MEM_AW-1:0] rd_addr_c, wr_addr_c;
    logic              disp_bank, wr_bank;
    logic [7:0]        mem [MEM_DEPTH];

    assign h_ext = 32'(h_cnt_q);
    assign v_ext = 32'(v_cnt_q);

    // Pixel divider, raster counters and the two-stage display pipeline
    always_comb begin
        pix_en_c  = (div_q == DIV_W'(CLK_DIV - 1));
        div_d     = pix_en_c ? '0 : div_q + DIV_W'(1);
        clk_out_d = (32'(div_d) < (CLK_DIV + 1) / 2);

        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_c) begin
            if (h_ext == H_TOTAL - 1) begin
                h_cnt_d = '0;
                v_cnt_d = (v_ext == V_TOTAL - 1) ? '0 : v_cnt_q + V_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + H_W'(1);
            end
        end

        active_c = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        hs_act_c = (h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC);
        vs_act_c = (v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC);
        // Blanking reads are parked on texel 0 so the address never leaves the bank
        texel_c   = active_c ? (v_ext / SCALE) * FB_W + h_ext / SCALE : 32'd0;
        rd_addr_c = MEM_AW'((disp_bank ? FB_SIZE : 0) + texel_c);

        hs1_d = pix_en_c ? (hs_act_c ? HS_POL : ~HS_POL) : hs1_q;
        vs1_d = pix_en_c ? (vs_act_c ? VS_POL : ~VS_POL) : vs1_q;
        de1_d = pix_en_c ? active_c : de1_q;

        hs_d    = pix_en_c ? hs1_q : hs_q;
        vs_d    = pix_en_c ? vs1_q : vs_q;
        de_d    = pix_en_c ? de1_q : de_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        if (pix_en_c) begin
            red_d   = de1_q ? {rd_data_q[7:5], rd_data_q[7:5], rd_data_q[7:6]} : 8'h00;
            green_d = de1_q ? {rd_data_q[4:2], rd_data_q[4:2], rd_data_q[4:3]} : 8'h00;
            blue_d  = de1_q ? {4{rd_data_q[1:0]}} : 8'h00;
        end

        wr_en_c   = fb_we && ({1'b0, fb_waddr} < FB_LIMIT);
        wr_addr_c = MEM_AW'((wr_bank ? FB_SIZE : 0) + 32'(fb_waddr));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= '0;
            clk_out_q <= 1'b1;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            hs1_q     <= ~HS_POL;
            vs1_q     <= ~VS_POL;
            de1_q     <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            de_q      <= 1'b0;
            red_q     <= 8'h00;
            green_q   <= 8'h00;
            blue_q    <= 8'h00;
        end else begin
            div_q     <= div_d;
            clk_out_q <= clk_out_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            de1_q     <= de1_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    // Texel RAM: contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= fb_wdata;
        end
        if (pix_en_c) begin
            rd_data_q <= mem[rd_addr_c];
        end
    end

`ifdef VGA_DOUBLE_BUF_EN
    typedef enum logic {ST_IDLE, ST_PENDING} swap_state_e;

    swap_state_e state_q, state_d;
    logic        front_sel_q, front_sel_d, swap_busy_q, swap_busy_d, vblank_c;

    // Swap is latched at any time but only committed at the first pixel of vblank
    always_comb begin
        vblank_c    = pix_en_c && (h_ext == 0) && (v_ext == V_ACTIVE);
        state_d     = state_q;
        front_sel_d = front_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (swap_req) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (vblank_c) begin
                    state_d     = ST_IDLE;
                    front_sel_d = ~front_sel_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        swap_busy_d = (state_d == ST_PENDING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            front_sel_q <= 1'b0;
            swap_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_busy_q <= swap_busy_d;
        end
    end

    assign swap_busy = swap_busy_q;
    assign front_sel = front_sel_q;
    assign disp_bank = front_sel_q;
    assign wr_bank   = ~front_sel_q;
`else
    logic unused_swap;

    assign unused_swap = swap_req;
    assign swap_busy   = 1'b0;
    assign front_sel   = 1'b0;
    assign disp_bank   = 1'b0;
    assign wr_bank     = 1'b0;
`endif

    assign clk_out   = clk_out_q;
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;
    assign de_out    = de_q;
    assign o_red     = red_q;
    assign o_green   = green_q;
    assign o_blue    = blue_q;

endmodule

// File: tb/tb_vga_fb_display.sv
// Bench for vga_fb_display on a reduced raster; expected outputs come from a frame/image model.
module tb_vga_fb_display;
    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned HA = 32, HFP = 4, HSY = 8, HBP = 4;
    localparam int unsigned VA = 16, VFP = 2, VSY = 2, VBP = 4;
    localparam int unsigned S = 4, AW = 6;
    localparam int unsigned HT = HA + HFP + HSY + HBP;
    localparam int unsigned VT = VA + VFP + VSY + VBP;
    localparam int unsigned F = HT * VT;
    localparam int unsigned FBW = HA / S, FBH = VA / S, FBS = FBW * FBH;
    localparam int unsigned IW = $clog2(FBS);
`ifdef VGA_DOUBLE_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fb_we = 1'b0;
    logic [AW-1:0] fb_waddr = '0;
    logic [7:0]    fb_wdata = 8'h00;
    logic          swap_req = 1'b0;
    logic          swap_busy, front_sel, clk_out, hsync_out, vsync_out, de_out;
    logic [7:0]    o_red, o_green, o_blue;
    logic [29:0]   obs;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  img [2][FBS];
    logic        mfront = 1'b0;

    vga_fb_display #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SCALE(S),
        .HS_POL(1'b0), .VS_POL(1'b0), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
        .swap_req(swap_req), .swap_busy(swap_busy), .front_sel(front_sel), .clk_out(clk_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
    );

    assign obs = {clk_out, swap_busy, front_sel, de_out, hsync_out, vsync_out, o_red, o_green, o_blue};

    always #5 clk = ~clk;

    // Clock edges since reset release; the model derives raster position from this
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [29:0] exp_vec(input int unsigned n, input bit busy);
        int unsigned t, q, h, v;
        logic [IW-1:0] idx;
        logic [7:0] tx, r, g, b;
        bit ck, de, hs, vs;
        t  = n / CLK_DIV;
        ck = (n % CLK_DIV) < (CLK_DIV + 1) / 2;
        de = 1'b0; hs = 1'b1; vs = 1'b1; r = 8'h00; g = 8'h00; b = 8'h00;
        if (t >= 2) begin
            q  = (t - 2) % F;
            h  = q % HT;
            v  = q / HT;
            de = (h < HA) && (v < VA);
            hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
            vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
            if (de) begin
                idx = IW'((v / S) * FBW + h / S);
                tx  = img[mfront][idx];
                r   = {tx[7:5], tx[7:5], tx[7:6]};
                g   = {tx[4:2], tx[4:2], tx[4:3]};
                b   = {4{tx[1:0]}};
            end
        end
        return {ck, busy, mfront, de, hs, vs, r, g, b};
    endfunction

    // First clock edge after request edge c at which the counters sit at (0, VA)
    function automatic int unsigned toggle_edge(input int unsigned c);
        int unsigned k;
        k = c / CLK_DIV + 1;
        while (((k - 1) % F) != VA * HT) k++;
        return k * CLK_DIV;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_line(input int unsigned line);
        while ((((cyc / CLK_DIV) % F) / HT) != line) step();
    endtask

    task automatic wait_disp(input int unsigned h, input int unsigned v);
        while (!((cyc / CLK_DIV) >= 2 && (((cyc / CLK_DIV) - 2) % F) == v * HT + h)) step();
    endtask

    task automatic write_texel(input logic [AW-1:0] a, input logic [7:0] d);
        logic bank;
        fb_we = 1'b1; fb_waddr = a; fb_wdata = d;
        step();
        fb_we = 1'b0;
        bank = DBL ? ~mfront : 1'b0;
        if (32'(a) < FBS) img[bank][IW'(a)] = d;
    endtask

    task automatic cmp_frame(input string tag);
        logic [29:0] e;
        repeat (6) step();
        repeat (F * CLK_DIV) begin
            step();
            e = exp_vec(cyc, 1'b0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, e);
            end
        end
    endtask

    task automatic do_swap(input string tag);
        int unsigned c, ke;
        logic old;
        old = mfront;
        swap_req = 1'b1;
        c = cyc + 1;
        step();
        swap_req = 1'b0;
        if (DBL) begin
            ke = toggle_edge(c);
            checks++;
            if (swap_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_busy_rise got=%b exp=1", tag, swap_busy);
            end
            while (cyc + 1 < ke) step();
            checks++;
            if ({swap_busy, front_sel} !== {1'b1, old}) begin
                errors++;
                $display("FAIL %s_pre_toggle got=%b%b exp=1%b", tag, swap_busy, front_sel, old);
            end
            step();
            mfront = ~old;
            checks++;
            if ({swap_busy, front_sel} !== {1'b0, ~old}) begin
                errors++;
                $display("FAIL %s_toggle cyc=%0d got=%b%b exp=0%b", tag, cyc, swap_busy, front_sel, ~old);
            end
        end else begin
            repeat (4) begin
                step();
                checks++;
                if ({swap_busy, front_sel} !== 2'b00) begin
                    errors++;
                    $display("FAIL %s_tied got=%b%b exp=00", tag, swap_busy, front_sel);
                end
            end
        end
    endtask

    task automatic test_timing(input string tag);
        int unsigned hs1, hs2, vs1, de1;
        logic phs, pvs;
        hs1 = 0; hs2 = 0; vs1 = 0; de1 = 0; phs = 1'b1; pvs = 1'b1;
        for (int i = 0; i < 2000 && vs1 == 0; i++) begin
            step();
            if (de_out === 1'b1 && de1 == 0) de1 = cyc;
            if (hsync_out === 1'b0 && phs === 1'b1) begin
                if (hs1 == 0) hs1 = cyc;
                else if (hs2 == 0) hs2 = cyc;
            end
            if (vsync_out === 1'b0 && pvs === 1'b1 && vs1 == 0) vs1 = cyc;
            phs = hsync_out; pvs = vsync_out;
        end
        checks++;
        if (de1 != 2 * CLK_DIV) begin
            errors++; $display("FAIL %s_first_de got=%0d exp=%0d", tag, de1, 2 * CLK_DIV);
        end
        checks++;
        if (hs1 != (HA + HFP + 2) * CLK_DIV) begin
            errors++; $display("FAIL %s_first_hsync got=%0d exp=%0d", tag, hs1, (HA + HFP + 2) * CLK_DIV);
        end
        checks++;
        if (hs2 != (HA + HFP + 2 + HT) * CLK_DIV) begin
            errors++; $display("FAIL %s_line_period got=%0d exp=%0d", tag, hs2, (HA + HFP + 2 + HT) * CLK_DIV);
        end
        checks++;
        if (vs1 != ((VA + VFP) * HT + 2) * CLK_DIV) begin
            errors++; $display("FAIL %s_first_vsync got=%0d exp=%0d", tag, vs1, ((VA + VFP) * HT + 2) * CLK_DIV);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== exp_vec(0, 1'b0)) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", obs, exp_vec(0, 1'b0));
        end
        reset = 1'b0;
        test_timing("timing");
    endtask

    task automatic test_fill();
        for (int b = 0; b < (DBL ? 2 : 1); b++) begin
            for (int a = 0; a < FBS; a++) write_texel(AW'(a), 8'($urandom));
            if (DBL && b == 0) do_swap("fill_swap");
        end
        cmp_frame("frame_fill");
    endtask

    task automatic test_swap_pattern();
        write_texel(AW'(0), 8'hE0);
        do_swap("swap_e0");
        cmp_frame("frame_e0");
        wait_disp(1, 1);
        checks++;
        if ({o_red, o_green, o_blue} !== 24'hFF0000) begin
            errors++; $display("FAIL pixel_1_1_red got=%h exp=ff0000", {o_red, o_green, o_blue});
        end
    endtask

    task automatic test_back_write();
        write_texel(AW'(FBW + 1), 8'h1C);
        cmp_frame("frame_noswap");
        do_swap("swap_1c");
        cmp_frame("frame_1c");
        wait_disp(4, 4);
        checks++;
        if ({o_red, o_green, o_blue} !== 24'h00FF00) begin
            errors++; $display("FAIL pixel_4_4_green got=%h exp=00ff00", {o_red, o_green, o_blue});
        end
    endtask

    task automatic test_multi_swap();
        int unsigned c, ke, changes, tog_at;
        logic prev;
        wait_line(1);
        prev = front_sel; changes = 0; tog_at = 0; c = 0;
        for (int i = 0; i < 2 * F * CLK_DIV; i++) begin
            swap_req = (i == 0 || i == 40 || i == 80);
            if (i == 0) c = cyc + 1;
            step();
            if (front_sel !== prev) begin
                changes++; tog_at = cyc; prev = front_sel;
            end
        end
        swap_req = 1'b0;
        ke = toggle_edge(c);
        checks++;
        if (changes != (DBL ? 1 : 0)) begin
            errors++; $display("FAIL multi_swap_count got=%0d exp=%0d", changes, DBL ? 1 : 0);
        end
        checks++;
        if (tog_at != (DBL ? ke : 0)) begin
            errors++; $display("FAIL multi_swap_edge got=%0d exp=%0d", tog_at, DBL ? ke : 0);
        end
        if (DBL) mfront = ~mfront;
        cmp_frame("frame_multi");
    endtask

    task automatic test_oob_write();
        write_texel(AW'(FBS), 8'($urandom));
        write_texel(AW'(FBS + 13), 8'($urandom));
        write_texel(AW'((1 << AW) - 1), 8'($urandom));
        cmp_frame("frame_oob_a");
        do_swap("swap_oob");
        cmp_frame("frame_oob_b");
    endtask

    task automatic test_reset_midframe();
        wait_line(2);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        wait_line(10);
        checks++;
        if (swap_busy !== DBL) begin
            errors++; $display("FAIL midframe_busy got=%b exp=%b", swap_busy, DBL);
        end
        #3 reset = 1'b1;
        #1;
        mfront = 1'b0;
        checks++;
        if (obs !== exp_vec(0, 1'b0)) begin
            errors++; $display("FAIL midframe_reset_state got=%h exp=%h", obs, exp_vec(0, 1'b0));
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_timing("restart");
        cmp_frame("frame_after_reset");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_swap_pattern();
        test_back_write();
        test_multi_swap();
        test_oob_write();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
